// File: rtl/flag_branch_unit.sv
// NZCV flag register and branch resolution for the LEGv8 datapath.
// Decision is registered one cycle after br_valid; same-cycle flag bypass from the ALU.
module flag_branch_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] cbz_val,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic             br_resolved,
  output logic             br_taken
);

  localparam logic [1:0] BR_B     = 2'b00;
  localparam logic [1:0] BR_CBZ   = 2'b01;
  localparam logic [1:0] BR_CBNZ  = 2'b10;

  // Radix-4 OR tree: number of levels so that 4**lvls covers WIDTH.
  localparam int LVLS = (WIDTH <= 4) ? 1 : ($clog2(WIDTH) + 1) / 2;
  localparam int PAD  = 4 ** LVLS;

  logic [PAD-1:0] padded;
  logic           is_zero;
  logic [3:0]     alu_flags;
  logic [3:0]     eff;
  logic           f_n, f_z, f_c, f_v;
  logic           cond_ok;
  logic           decision;

  assign padded = PAD'(cbz_val);

  genvar l, i;
  for (l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = PAD / (4 ** l);
    logic [N-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = padded;
    end else begin : g_node
      for (i = 0; i < N; i++) begin : g_or
        assign v[i] = |g_lvl[l-1].v[4*i +: 4];
      end
    end
  end

  assign is_zero   = ~g_lvl[LVLS].v[0];
  assign alu_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
  assign eff       = set_flags ? alu_flags : flags_q;
  assign {f_n, f_z, f_c, f_v} = eff;

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      4'b0000: cond_ok = f_z;
      4'b0001: cond_ok = ~f_z;
      4'b0010: cond_ok = f_c;
      4'b0011: cond_ok = ~f_c;
      4'b0100: cond_ok = f_n;
      4'b0101: cond_ok = ~f_n;
      4'b0110: cond_ok = f_v;
      4'b0111: cond_ok = ~f_v;
      4'b1000: cond_ok = f_c & ~f_z;
      4'b1001: cond_ok = ~f_c | f_z;
      4'b1010: cond_ok = (f_n == f_v);
      4'b1011: cond_ok = (f_n != f_v);
      4'b1100: cond_ok = ~f_z & (f_n == f_v);
      4'b1101: cond_ok = f_z | (f_n != f_v);
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    decision = cond_ok;
    case (br_type)
      BR_B:    decision = 1'b1;
      BR_CBZ:  decision = is_zero;
      BR_CBNZ: decision = ~is_zero;
      default: decision = cond_ok;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      br_resolved <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      if (set_flags && !stall)
        flags_q <= alu_flags;
      if (flush) begin
        br_resolved <= 1'b0;
        br_taken    <= 1'b0;
      end else if (stall) begin
        br_resolved <= 1'b0;
      end else begin
        br_resolved <= br_valid;
        br_taken    <= br_valid & decision;
      end
    end
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Condition-flag register and branch-resolution stage for the 64-bit LEGv8 datapath. It latches the N/Z/C/V flags produced alongside the ALU result, then evaluates CBZ, CBNZ, B.cond and unconditional B against those flags or a register operand. It registers a taken/not-taken decision for the fetch unit. It sits between the ALU flag outputs and the PC-select logic, and owns the only architectural copy of NZCV.

## Interface
- `WIDTH`, 64, width of the CBZ/CBNZ test operand.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `alu_neg`, `alu_zero`, `alu_carry`, `alu_ovf`  in  1 each  flags from the current EX-stage ALU operation.
- `set_flags`  in  1  current EX instruction is a flag-setting op (ADDS/SUBS/ANDS).
- `br_valid`  in  1  a branch is presented this cycle.
- `br_type`  in  2  00 = B (unconditional), 01 = CBZ, 10 = CBNZ, 11 = B.cond.
- `cond`  in  4  LEGv8 condition code for B.cond; ignored otherwise.
- `cbz_val`  in  WIDTH  register operand for CBZ/CBNZ.
- `stall`  in  1  pipeline hold.
- `flush`  in  1  squash the branch in flight.
- `flags_q`  out  4  architectural {N,Z,C,V}.
- `br_resolved`  out  1  one-cycle pulse: a branch decision is valid.
- `br_taken`  out  1  decision; meaningful only while `br_resolved` = 1.

## Operation
- Reset values: `flags_q` = 4'b0000, `br_resolved` = 0, `br_taken` = 0.
- Flag register: on an edge with `set_flags` = 1 and `stall` = 0, `flags_q` <= {alu_neg, alu_zero, alu_carry, alu_ovf}. Otherwise it holds.
- Effective flags for evaluation:
  - If `set_flags` = 1 in the same cycle as `br_valid`, use the incoming ALU flags (bypass).
  - Otherwise use `flags_q`.
- Operand test: CBZ is taken iff all WIDTH bits of `cbz_val` are 0. CBNZ is the inverse. Neither reads the flags.
- B is always taken.
- B.cond decode, using the effective flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 HS: C
  - 0011 LO: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 and 1111: always taken
- Resolution register, with priority flush > stall > normal:
  - flush = 1: `br_resolved` <= 0, `br_taken` <= 0. The flag update still follows the `set_flags`/`stall` rule.
  - stall = 1 (no flush): `br_resolved` <= 0, `br_taken` holds, and `br_valid` is ignored. The branch is represented after the stall.
  - normal: `br_resolved` <= `br_valid`, `br_taken` <= `br_valid` & decision.
- Back-to-back branches resolve one per cycle with no bubble.

## Timing
- Latency: a decision appears on `br_resolved`/`br_taken` the cycle after `br_valid` is sampled (1 cycle).
- `flags_q` reflects a flag-setting op one cycle after it is sampled.
- The same-cycle bypass keeps B.cond directly after SUBS at zero penalty.
- Reset asserted mid-operation clears `flags_q` and any pending resolution asynchronously, with no edge required. The first resolution after deassertion requires a new `br_valid`.
- Critical path: the WIDTH-bit zero reduction plus the condition mux must fit in one cycle. Implement the zero test as a balanced reduction tree of gates of no more than 4 inputs each.

## Test plan
- Reset, then B.cond EQ with `flags_q` = 0000 and `set_flags` = 0 -> next cycle `br_resolved` = 1, `br_taken` = 0; `flags_q` stays 0000.
- Reset flags, then SUBS with `set_flags` = 1 and ALU flags N=1 Z=0 C=0 V=0, in the same cycle as B.cond LT (1011) -> bypass gives N != V, so `br_taken` = 1 next cycle. `flags_q` = 4'b1000 after that edge.
- CBZ with `cbz_val` = 0 -> taken. CBZ with `cbz_val` = 64'h8000_0000_0000_0000 -> not taken. CBNZ with `cbz_val` = 64'd4390270857 -> taken.
- Stored flags 0110 (Z=1, C=1), then B.cond HI (1000) -> not taken. B.cond LS (1001) -> taken. B.cond AL (1110) -> taken.
- `br_valid` and `set_flags` with `stall` = 1 for 2 cycles -> `br_resolved` = 0 and `flags_q` unchanged. When the branch is represented with `stall` = 0, it resolves next cycle.
- `flush` = 1 together with `br_valid` (B) and `set_flags` (flags 0100) -> `br_resolved` = 0 next cycle and `flags_q` = 0100. Asserting `reset` mid-cycle afterwards -> all outputs 0 immediately.
